char_uart_tx: RTL and testbench
===============================

// Module: char_uart_tx
// PURPOSE
//  Downstream consumer of the decimal-to-ASCII converter: captures its character
//  stream (one char per cycle while valid high) into a FIFO and serialises it as
//  8N1 UART on txd, optionally terminating each burst with CR LF. Decouples the
//  one-char-per-clock burst from the slow serial line.
// PARAMETERS
//  CLK_DIV      434  clocks per UART bit (50 MHz / 115200); legal >= 2
//  DEPTH        16   FIFO entries; power of two, >= 2
//  APPEND_CRLF  1    1: enqueue 0x0D,0x0A after each valid_i burst; 0: none
// PORTS
//  CLK          in   1   clock; all logic on posedge
//  RST          in   1   reset, asynchronous, active-high
//  char_i       in   8   ASCII char, sampled every cycle valid_i=1
//  valid_i      in   1   char_i valid this cycle (no backpressure)
//  txd          out  1   UART serial out, idle high
//  busy         out  1   1 while FIFO non-empty, CRLF pending, or frame in flight
//  overflow     out  1   sticky: a char (input or CR/LF) was dropped on full FIFO
//  fifo_level   out  clog2(DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//  Reset (async, RST=1): txd=1, busy=0, overflow=0, fifo_level=0, FIFO emptied,
//   CRLF pending cleared, FSM=IDLE. Mid-frame reset aborts frame at once (txd=1).
//  FIFO write: valid_i=1 and level<DEPTH -> char_i stored. Level==DEPTH -> drop,
//   overflow<=1. Full test uses pre-cycle level; same-cycle pop does not free room.
//  Simultaneous write+pop: level unchanged; both take effect.
//  CRLF (APPEND_CRLF=1): falling edge of valid_i (1 last cycle, 0 now) sets
//   pending=2. Each cycle with valid_i=0 and pending>0 enqueues 0x0D (pending=2)
//   then 0x0A (pending=1), decrementing. valid_i=1 has priority: insertion stalls,
//   resumes when valid_i drops; a new falling edge while pending>0 reloads 2.
//   CR/LF hitting full FIFO: dropped, overflow<=1, pending still decrements.
//  TX FSM, bit counter counts CLK_DIV cycles per bit:
//   IDLE : txd=1. If level>0: pop head into shift reg -> START.
//   START: txd=0 for CLK_DIV cycles -> DATA.
//   DATA : 8 bits LSB first, CLK_DIV cycles each -> STOP.
//   STOP : txd=1 for CLK_DIV cycles -> IDLE.
//  Latency: char written cycle N -> visible in FIFO N+1 -> popped in IDLE at N+1
//   -> txd low from N+2. Back-to-back frames: stop high CLK_DIV cycles plus one
//   IDLE cycle (stop effectively CLK_DIV+1). Frame = 10*CLK_DIV cycles.
//  busy = (FSM!=IDLE) | (level>0) | (pending>0), combinational from registers.
//  Pointers wrap modulo DEPTH; level saturates logically at DEPTH via full check.
//  overflow clears only on reset.
// TESTING (CLK_DIV=4, DEPTH=16 unless noted)
//  1. APPEND_CRLF=0, one-cycle valid_i, char_i=0x35 at cycle 0 -> txd low cycles
//     2-5, then bits 1,0,1,0,1,1,0,0 (4 cycles each), stop high; busy drops after
//     stop, frame total 40 cycles.
//  2. APPEND_CRLF=1, burst "1","2" (2 cycles) -> frames 0x31,0x32,0x0D,0x0A in
//     order; single idle cycle between each stop and next start; overflow=0.
//  3. DEPTH=4, APPEND_CRLF=0, 8-cycle burst c0..c7 -> c0..c4 transmitted, c5..c7
//     dropped, overflow=1 at cycle 6 and held; fifo_level peaks at 4.
//  4. RST pulsed during DATA bit 3 of frame with 3 chars queued -> txd=1 same
//     cycle, fifo_level=0, busy=0, no further frames; next char sent normally.
//  5. APPEND_CRLF=1, burst "A", 1 idle cycle, burst "B" -> CR enqueued between,
//     pending reloaded: frames 0x41,0x0D,0x42,0x0D,0x0A.
//  6. Write during pop with FIFO full (DEPTH=4) -> write dropped, overflow=1,
//     level 4->3.

Source files
------------

// File: rtl/char_uart_tx.sv
// Character FIFO feeding an 8N1 UART transmitter; optionally appends CR LF after
// each input burst so the one-char-per-clock stream can drain at line rate.
module char_uart_tx #(
    parameter int unsigned CLK_DIV     = 434,
    parameter int unsigned DEPTH       = 16,
    parameter bit          APPEND_CRLF = 1'b1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [7:0]               char_i,
    input  logic                     valid_i,
    output logic                     txd,
    output logic                     busy,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned CW = $clog2(CLK_DIV);
    localparam logic [LW-1:0] FULL     = LW'(DEPTH);
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [1:0]    pending;
    logic          valid_q;
    logic [CW-1:0] div_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    logic          fall;
    logic [1:0]    pend_eff;
    logic          crlf_go;
    logic          wr_req;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          pop;

    // A falling edge of valid_i acts as pending=2 in the same cycle, so the CR
    // goes in immediately and a reload mid-sequence restarts from CR.
    always_comb begin
        fall     = APPEND_CRLF && valid_q && !valid_i;
        pend_eff = fall ? 2'd2 : pending;
        crlf_go  = APPEND_CRLF && !valid_i && (pend_eff != 2'd0);
        wr_req   = valid_i || crlf_go;
        wr_data  = valid_i ? char_i : ((pend_eff == 2'd2) ? 8'h0D : 8'h0A);
        wr_en    = wr_req && (fifo_level != FULL);
        pop      = (state == IDLE) && (fifo_level != '0);
    end

    assign busy = (state != IDLE) || (fifo_level != '0) || (pending != 2'd0);

    always_ff @(posedge CLK) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            txd        <= 1'b1;
            overflow   <= 1'b0;
            fifo_level <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            pending    <= 2'd0;
            valid_q    <= 1'b0;
            div_cnt    <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
        end else begin
            valid_q <= valid_i;
            if (crlf_go) pending <= pend_eff - 2'd1;
            if (wr_req && !wr_en) overflow <= 1'b1;
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_level <= fifo_level + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, pop};

            case (state)
                IDLE: begin
                    txd <= 1'b1;
                    if (pop) begin
                        shreg   <= mem[rd_ptr];
                        div_cnt <= '0;
                        txd     <= 1'b0;
                        state   <= START;
                    end
                end
                START: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        bit_idx <= '0;
                        txd     <= shreg[0];
                        state   <= DATA;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            txd   <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            shreg   <= shreg >> 1;
                            txd     <= shreg[1];
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= '0;
                        state   <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_char_uart_tx.sv
// Directed bench for char_uart_tx: three instances (no CRLF / CRLF / 4-deep FIFO)
// share stimulus; each step checks the instance it targets.
module tb_char_uart_tx;

    localparam logic [7:0] EXP2 [4] = '{8'h31, 8'h32, 8'h0D, 8'h0A};
    localparam logic [7:0] EXP5 [5] = '{8'h41, 8'h0D, 8'h42, 8'h0D, 8'h0A};

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] char_i = '0;
    logic       valid_i = 1'b0;

    logic       txd_a, busy_a, ovf_a;
    logic [4:0] lvl_a;
    logic       txd_b, busy_b, ovf_b;
    logic [4:0] lvl_b;
    logic       txd_c, busy_c, ovf_c;
    logic [2:0] lvl_c;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    char_uart_tx #(.CLK_DIV(4), .DEPTH(16), .APPEND_CRLF(1'b0)) dut_a (
        .CLK(CLK), .RST(RST), .char_i(char_i), .valid_i(valid_i),
        .txd(txd_a), .busy(busy_a), .overflow(ovf_a), .fifo_level(lvl_a));

    char_uart_tx #(.CLK_DIV(4), .DEPTH(16), .APPEND_CRLF(1'b1)) dut_b (
        .CLK(CLK), .RST(RST), .char_i(char_i), .valid_i(valid_i),
        .txd(txd_b), .busy(busy_b), .overflow(ovf_b), .fifo_level(lvl_b));

    char_uart_tx #(.CLK_DIV(4), .DEPTH(4), .APPEND_CRLF(1'b0)) dut_c (
        .CLK(CLK), .RST(RST), .char_i(char_i), .valid_i(valid_i),
        .txd(txd_c), .busy(busy_c), .overflow(ovf_c), .fifo_level(lvl_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic get_txd(input int which);
        return (which == 0) ? txd_a : (which == 1) ? txd_b : txd_c;
    endfunction

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1; valid_i = 1'b0; char_i = '0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
    endtask

    // Sample near mid-bit: start detected on its first low sample, then +2, then every 4.
    task automatic rx(input int which, output logic [7:0] d, output int t0);
        int n = 0;
        d  = '0;
        t0 = 0;
        while (get_txd(which) !== 1'b0 && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        chk("rx_start_seen", n < 3000, 1);
        if (n >= 3000) return;
        t0 = cyc;
        repeat (2) @(negedge CLK);
        chk("rx_start_bit", get_txd(which), 0);
        for (int b = 0; b < 8; b++) begin
            repeat (4) @(negedge CLK);
            d[b] = get_txd(which);
        end
        repeat (4) @(negedge CLK);
        chk("rx_stop_bit", get_txd(which), 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rxd;
        logic [7:0] b35;
        logic       e;
        int         t, tp, lowcnt;
        int         exp_lvl [8];

        // Reset state of all instances
        do_reset();
        chk("rst_txd_a", txd_a, 1);  chk("rst_busy_a", busy_a, 0);
        chk("rst_ovf_a", ovf_a, 0);  chk("rst_lvl_a", lvl_a, 0);
        chk("rst_txd_b", txd_b, 1);  chk("rst_busy_b", busy_b, 0);
        chk("rst_ovf_b", ovf_b, 0);  chk("rst_lvl_b", lvl_b, 0);
        chk("rst_txd_c", txd_c, 1);  chk("rst_busy_c", busy_c, 0);
        chk("rst_ovf_c", ovf_c, 0);  chk("rst_lvl_c", lvl_c, 0);

        // Test 1: single 0x35, exact cycle-by-cycle waveform and busy
        b35 = 8'h35;
        @(negedge CLK); valid_i = 1'b1; char_i = 8'h35;
        for (int j = 0; j < 42; j++) begin
            @(negedge CLK); valid_i = 1'b0;
            if (j == 0 || j >= 37) e = 1'b1;
            else if (j <= 4)       e = 1'b0;
            else                   e = b35[(j - 5) / 4];
            chk("t1_txd", txd_a, e);
            chk("t1_busy", busy_a, (j <= 40) ? 1 : 0);
        end

        // Test 2: burst "12" with CRLF, back-to-back frames 41 cycles apart
        do_reset();
        fork
            begin
                @(negedge CLK); valid_i = 1'b1; char_i = 8'h31;
                @(negedge CLK); char_i = 8'h32;
                @(negedge CLK); valid_i = 1'b0;
            end
            begin
                tp = 0;
                for (int i = 0; i < 4; i++) begin
                    rx(1, rxd, t);
                    chk("t2_char", rxd, EXP2[i]);
                    if (i > 0) chk("t2_start_spacing", t - tp, 41);
                    tp = t;
                end
            end
        join
        chk("t2_ovf", ovf_b, 0);
        repeat (3) @(negedge CLK);
        chk("t2_busy_end", busy_b, 0);

        // Test 3: 4-deep FIFO, 8-char burst, c5..c7 dropped
        exp_lvl = '{0, 1, 1, 2, 3, 4, 4, 4};
        do_reset();
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    @(negedge CLK);
                    chk("t3_level", lvl_c, exp_lvl[k]);
                    chk("t3_ovf", ovf_c, (k >= 6) ? 1 : 0);
                    valid_i = 1'b1; char_i = 8'(8'h60 + k);
                end
                @(negedge CLK); valid_i = 1'b0;
                chk("t3_level_after", lvl_c, 4);
                chk("t3_ovf_after", ovf_c, 1);
            end
            begin
                for (int i = 0; i < 5; i++) begin
                    rx(2, rxd, t);
                    chk("t3_char", rxd, 8'(8'h60 + i));
                end
            end
        join
        repeat (3) @(negedge CLK);
        chk("t3_busy_end", busy_c, 0);
        chk("t3_ovf_sticky", ovf_c, 1);

        // Test 4: async reset during DATA bit 3 with 3 chars queued
        do_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK); valid_i = 1'b1; char_i = 8'(8'h30 + k);
        end
        @(negedge CLK); valid_i = 1'b0;
        repeat (15) @(negedge CLK);
        chk("t4_bit3_pre", txd_a, 0);
        chk("t4_level_pre", lvl_a, 3);
        RST = 1'b1;
        #1;
        chk("t4_txd_rst", txd_a, 1);
        chk("t4_level_rst", lvl_a, 0);
        chk("t4_busy_rst", busy_a, 0);
        @(negedge CLK); RST = 1'b0;
        lowcnt = 0;
        for (int j = 0; j < 60; j++) begin
            @(negedge CLK);
            if (txd_a !== 1'b1 || busy_a !== 1'b0) lowcnt++;
        end
        chk("t4_quiet_after_rst", lowcnt, 0);
        @(negedge CLK); valid_i = 1'b1; char_i = 8'h5A;
        @(negedge CLK); valid_i = 1'b0;
        rx(0, rxd, t);
        chk("t4_char_after_rst", rxd, 8'h5A);

        // Test 5: "A", idle, "B" with CRLF: CR between, pending reloaded
        do_reset();
        fork
            begin
                @(negedge CLK); valid_i = 1'b1; char_i = 8'h41;
                @(negedge CLK); valid_i = 1'b0;
                @(negedge CLK); valid_i = 1'b1; char_i = 8'h42;
                @(negedge CLK); valid_i = 1'b0;
            end
            begin
                for (int i = 0; i < 5; i++) begin
                    rx(1, rxd, t);
                    chk("t5_char", rxd, EXP5[i]);
                end
            end
        join
        chk("t5_ovf", ovf_b, 0);
        repeat (3) @(negedge CLK);
        chk("t5_busy_end", busy_b, 0);

        // Test 6: write on the same cycle as a pop from a full 4-deep FIFO
        do_reset();
        fork
            begin
                for (int k = 0; k < 5; k++) begin
                    @(negedge CLK); valid_i = 1'b1; char_i = 8'(8'h70 + k);
                end
                @(negedge CLK); valid_i = 1'b0;
                repeat (37) @(negedge CLK);
                chk("t6_level_full", lvl_c, 4);
                chk("t6_ovf_pre", ovf_c, 0);
                valid_i = 1'b1; char_i = 8'h77;
                @(negedge CLK); valid_i = 1'b0;
                chk("t6_level_after_pop", lvl_c, 3);
                chk("t6_ovf_post", ovf_c, 1);
            end
            begin
                for (int i = 0; i < 5; i++) begin
                    rx(2, rxd, t);
                    chk("t6_char", rxd, 8'(8'h70 + i));
                end
            end
        join
        repeat (3) @(negedge CLK);
        chk("t6_busy_end", busy_c, 0);
        chk("t6_level_end", lvl_c, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
